buffer_reader: RTL and testbench
================================

BUFFER_READER -- requirements
Module: buffer_reader

Interface
REQ-001 The module SHALL take parameter LANES, default 4, giving the number of W-bit elements per captured word (LANES >= 2).
REQ-002 The module SHALL take parameter W, default 16, giving the element width in bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 d_in  input  LANES*W  captured word; lane k occupies bits [k*W+W-1 : k*W].
REQ-006 done  input  1  one-cycle load strobe from the capturing stage; d_in is valid in the same cycle.
REQ-007 out_ready  input  1  downstream accepts out_data this cycle.
REQ-008 out_data  output  W  current element.
REQ-009 out_valid  output  1  out_data holds a valid element.
REQ-010 out_last  output  1  current element is lane LANES-1.
REQ-011 out_idx  output  $clog2(LANES)  lane index of the current element.
REQ-012 busy  output  1  a word is being streamed.
REQ-013 overrun  output  1  sticky flag: a load was dropped.
REQ-014 frame_cnt  output  16  count of completely streamed words; wraps modulo 2^16.

Function
REQ-015 The module SHALL implement a two-state FSM: IDLE and STREAM.
- IDLE + done=1 -> STREAM.
- STREAM + final transfer + done=0 -> IDLE.
- STREAM + final transfer + done=1 -> STREAM (reload).
REQ-016 In IDLE with done=1, the module SHALL latch d_in into an internal shadow register and set idx to 0.
REQ-017 out_valid SHALL be asserted on the cycle after the load.
REQ-018 out_valid SHALL equal (state==STREAM) and busy SHALL equal out_valid.
REQ-019 out_data SHALL be shadow lane idx, driven from registers with no combinational path from d_in.
REQ-020 A transfer SHALL occur on any cycle with out_valid=1 and out_ready=1.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-022 On a transfer with idx < LANES-1, idx SHALL increment by 1.
REQ-023 out_last SHALL equal out_valid && (idx == LANES-1).
REQ-024 The transfer with out_last=1 is the final transfer; on it, frame_cnt SHALL increment by 1 (0xFFFF wraps to 0x0000).
REQ-025 If done=1 on the final transfer cycle, the module SHALL load the new d_in with idx=0 and hold out_valid high with no bubble.
REQ-026 If done=1 in STREAM on any other cycle, that load SHALL be dropped, the shadow SHALL remain unchanged, and overrun SHALL set to 1 on the next edge.
REQ-027 overrun SHALL stay set until reset.
REQ-028 done=1 in IDLE SHALL never set overrun.
REQ-029 out_ready SHALL be ignored in IDLE.
REQ-030 Minimum latency from done to the first valid element SHALL be 1 cycle.
REQ-031 Streaming one word SHALL take at least LANES cycles.

Reset
REQ-032 On reset, the module SHALL enter IDLE and clear idx to 0.
- out_valid=0, out_last=0, busy=0, overrun=0, frame_cnt=0, out_idx=0.
- out_data and the shadow register SHALL be cleared to 0.
REQ-033 Reset asserted mid-stream SHALL abandon the word without completing frame_cnt.
REQ-034 reset SHALL take priority over done on the same edge.

Structure
REQ-035 A shared package SHALL hold the FSM state typedef (IDLE, STREAM) and the frame_cnt width constant (16).
REQ-036 Lane selection and counters SHALL be inline; no sub-module is required.

Verification (LANES=4, W=16)
REQ-037 Basic stream: done with d_in=0x0004_0003_0002_0001 and out_ready held 1 -> out_data 0x0001,0x0002,0x0003,0x0004 on 4 consecutive cycles; out_last only on 0x0004; frame_cnt=1; then IDLE.
REQ-038 Backpressure: same word with out_ready=0 for 3 cycles at idx=2 -> out_data holds 0x0003 and out_idx holds 2 for all 3 cycles; no element lost or duplicated.
REQ-039 Back-to-back: second done with 0x0008_0007_0006_0005 on the final-transfer cycle of the first word -> 8 elements 1..8 with no valid gap; frame_cnt=2; overrun=0.
REQ-040 Overrun: done at idx=1 mid-stream -> stream continues with the original data; overrun=1 from the next cycle and stays set; the dropped word never appears.
REQ-041 Reset mid-stream: reset at idx=2 -> next cycle out_valid=0, overrun=0, frame_cnt=0; a subsequent done streams the new word from lane 0.
REQ-042 Wrap: force 65536 words through the block -> frame_cnt reads 0x0000.

Source files
------------

// File: rtl/buffer_reader_pkg.sv
// Shared types and constants for the buffer reader.
package buffer_reader_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/buffer_reader.sv
// Captures a LANES*W word on done and streams it one W-bit lane per accepted transfer.
// First element valid 1 cycle after done; holds on !out_ready; a load on the final transfer reloads bubble-free.
module buffer_reader
    import buffer_reader_pkg::*;
#(
    parameter int LANES = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LANES*W-1:0]       d_in,
    input  logic                     done,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [$clog2(LANES)-1:0] out_idx,
    output logic                     busy,
    output logic                     overrun,
    output logic [FRAME_CNT_W-1:0]   frame_cnt
);

    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [LANES-1:0][W-1:0]      shadow_q, shadow_d;
    logic                         overrun_q, overrun_d;
    logic [FRAME_CNT_W-1:0]       frame_cnt_q, frame_cnt_d;

    logic xfer;
    logic final_xfer;

    assign xfer       = (state_q == STREAM) && out_ready;
    assign final_xfer = xfer && (idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            IDLE: begin
                if (done) begin
                    shadow_d = d_in;
                    idx_d    = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (final_xfer) begin
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                    idx_d       = '0;
                    if (done) begin
                        // Reload in place so out_valid never drops between words.
                        shadow_d = d_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (done) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Output lane mux reads only registered state, never d_in.
    assign out_data  = shadow_q[idx_q];
    assign out_valid = (state_q == STREAM);
    assign busy      = out_valid;
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign out_idx   = idx_q;
    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_buffer_reader.sv
// Randomized and directed stimulus for buffer_reader, checked against a queue-based element model.
module tb_buffer_reader;

    localparam int LANES = 4;
    localparam int W     = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [LANES*W-1:0]   d_in;
    logic                 done;
    logic                 out_ready;
    logic [W-1:0]         out_data;
    logic                 out_valid;
    logic                 out_last;
    logic [1:0]           out_idx;
    logic                 busy;
    logic                 overrun;
    logic [15:0]          frame_cnt;

    buffer_reader #(.LANES(LANES), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .d_in      (d_in),
        .done      (done),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .busy      (busy),
        .overrun   (overrun),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: elements of the current word still to be delivered.
    logic [W-1:0] m_q[$];
    logic         m_ovr;
    logic [15:0]  m_frames;
    bit           m_fresh;
    int           m_words_seen;

    localparam logic [63:0] WORD_A = 64'h0004_0003_0002_0001;
    localparam logic [63:0] WORD_B = 64'h0008_0007_0006_0005;
    localparam logic [63:0] WORD_X = 64'hDEAD_BEEF_CAFE_F00D;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit xfer;
        bit fin;
        if (reset) begin
            m_q.delete();
            m_ovr    = 1'b0;
            m_frames = '0;
            m_fresh  = 1'b1;
        end else begin
            xfer = (m_q.size() > 0) && out_ready;
            fin  = xfer && (m_q.size() == 1);
            if (xfer) void'(m_q.pop_front());
            if (fin) m_frames = m_frames + 16'd1;
            if (done) begin
                if (m_q.size() == 0) begin
                    for (int k = 0; k < LANES; k++) m_q.push_back(d_in[k*W +: W]);
                    m_fresh = 1'b0;
                    m_words_seen++;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    endtask

    task automatic compare();
        bit v;
        v = (m_q.size() > 0);
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("busy", 32'(busy), 32'(v));
        chk("out_last", 32'(out_last), 32'(v && m_q.size() == 1));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
        if (v) begin
            chk("out_data", 32'(out_data), 32'(m_q[0]));
            chk("out_idx", 32'(out_idx), 32'(LANES - m_q.size()));
        end else if (m_fresh) begin
            chk("out_data_rst", 32'(out_data), 32'h0);
            chk("out_idx_rst", 32'(out_idx), 32'h0);
        end
    endtask

    task automatic step(input logic rst_v, input logic done_v, input logic [63:0] d_v,
                        input logic rdy_v);
        reset     = rst_v;
        done      = done_v;
        d_in      = d_v;
        out_ready = rdy_v;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (m_q.size() > 0 && guard < 50) begin
            step(1'b0, 1'b0, WORD_X, 1'b1);
            guard++;
        end
        if (m_q.size() > 0) chk("drain_timeout", 32'(guard), 32'(0));
    endtask

    initial begin
        m_ovr        = 1'b0;
        m_frames     = '0;
        m_fresh      = 1'b1;
        m_words_seen = 0;
        reset = 1'b1; done = 1'b0; d_in = '0; out_ready = 1'b0;
        @(negedge clk);

        // Reset state, with done asserted to confirm reset wins.
        step(1'b1, 1'b1, WORD_X, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);

        // Basic stream with out_ready held high.
        step(1'b0, 1'b1, WORD_A, 1'b1);
        drain();
        step(1'b0, 1'b0, WORD_X, 1'b1);

        // Backpressure at idx 2 for three cycles.
        step(1'b0, 1'b1, WORD_A, 1'b1);
        step(1'b0, 1'b0, WORD_X, 1'b1);
        step(1'b0, 1'b0, WORD_X, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, WORD_X, 1'b0);
        drain();

        // Back-to-back: second load on the final transfer.
        step(1'b0, 1'b1, WORD_A, 1'b1);
        while (m_q.size() > 1) step(1'b0, 1'b0, WORD_X, 1'b1);
        step(1'b0, 1'b1, WORD_B, 1'b1);
        chk("b2b_no_gap", 32'(out_valid), 32'h1);
        drain();

        // Overrun: load at idx 1 is dropped.
        step(1'b0, 1'b1, WORD_B, 1'b1);
        step(1'b0, 1'b0, WORD_X, 1'b1);
        step(1'b0, 1'b1, WORD_X, 1'b1);
        chk("overrun_set", 32'(overrun), 32'h1);
        drain();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, WORD_X, 1'b1);

        // Reset mid-stream at idx 2, then a fresh word from lane 0.
        step(1'b0, 1'b1, WORD_A, 1'b1);
        step(1'b0, 1'b0, WORD_X, 1'b1);
        step(1'b0, 1'b0, WORD_X, 1'b1);
        step(1'b1, 1'b0, WORD_X, 1'b1);
        chk("rst_mid_valid", 32'(out_valid), 32'h0);
        step(1'b0, 1'b1, WORD_B, 1'b1);
        chk("rst_mid_lane0", 32'(out_data), 32'h5);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] w;
            w = {$urandom, $urandom};
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), w,
                 ($urandom_range(0, 3) != 0));
        end
        drain();

        // Counter wrap: preset near the top, then stream two words.
        step(1'b0, 1'b0, WORD_X, 1'b0);
        force dut.frame_cnt_q = 16'hFFFE;
        #1;
        release dut.frame_cnt_q;
        m_frames = 16'hFFFE;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, {$urandom, $urandom}, 1'b1);
            drain();
        end
        chk("wrap_zero", 32'(frame_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
